// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 initiator for SD cards: MSB first, programmable half-period,
// one active-low chip select per card. Everything runs on bus_clk.
module sd_spi_master #(
    parameter int DIV_WIDTH = 8,
    parameter int NUM_CS    = 2
) (
    input  logic                 bus_clk,
    input  logic                 bus_reset,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic [7:0]           tx_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           rx_data,
    input  logic                 cs_write,
    input  logic [NUM_CS-1:0]    cs_value,
    output logic [NUM_CS-1:0]    sd_cs,
    output logic                 sd_clock,
    output logic                 sd_di,
    input  logic                 sd_do
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [DIV_WIDTH-1:0] r_div_reg;
    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_tx_shift;
    logic [7:0]           r_rx_shift;
    logic [7:0]           r_rx_data;
    logic                 r_done;
    logic [NUM_CS-1:0]    r_sd_cs;
    logic                 w_tick;

    assign w_tick = (r_div_cnt == '0);

    always_ff @(posedge bus_clk) begin
        if (bus_reset) r_state <= IDLE;
        else           r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_next_state = LOW;
            LOW:     if (w_tick) w_next_state = HIGH;
            HIGH:    if (w_tick) w_next_state = (r_bit_cnt == 3'd7) ? IDLE : LOW;
            default: w_next_state = IDLE;
        endcase
    end

    // Serial outputs follow the state directly; MOSI idles high between bytes.
    always_comb begin
        busy     = (r_state != IDLE);
        sd_clock = (r_state == HIGH);
        sd_di    = (r_state == IDLE) ? 1'b1 : r_tx_shift[7];
        done     = r_done;
        rx_data  = r_rx_data;
        sd_cs    = r_sd_cs;
    end

    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            r_div_reg  <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_done     <= 1'b0;
            r_sd_cs    <= '1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (cs_write) r_sd_cs <= cs_value;
                    if (start) begin
                        r_div_reg  <= divider;
                        r_div_cnt  <= divider;
                        r_tx_shift <= tx_data;
                        r_bit_cnt  <= '0;
                    end
                end
                LOW: begin
                    // MISO is captured on the edge that raises sd_clock.
                    if (w_tick) begin
                        r_div_cnt  <= r_div_reg;
                        r_rx_shift <= {r_rx_shift[6:0], sd_do};
                    end else begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (w_tick) begin
                        if (r_bit_cnt != 3'd7) begin
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            r_div_cnt  <= r_div_reg;
                        end else begin
                            r_rx_data <= r_rx_shift;
                            r_done    <= 1'b1;
                            r_bit_cnt <= '0;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
